// File: rtl/mult_control_param.sv
// Sequencer for a shift-add multiplier: one ADD/SHIFT pair per operand bit, optional signed final subtract.
// Optional abort is enabled by defining MULT_CTRL_ABORT_EN.
module mult_control_param #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Execute,
    input  logic M,
    input  logic Abort,
    output logic ClrA_LdB,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          abort_req;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_req = Abort;
`else
    logic unused_abort;
    assign unused_abort = Abort;
    assign abort_req    = 1'b0;
`endif

    assign last = (cnt == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (abort_req && state != IDLE) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Execute && !abort_req) state <= LOAD;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (last) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    // Leaving DONE requires Execute to drop, so a held request runs only once.
                    if (!Execute) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        ClrA_LdB = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift    = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            LOAD: begin
                ClrA_LdB = 1'b1;
                Busy     = 1'b1;
            end
            ADD: begin
                Busy = 1'b1;
                // The signed multiplier MSB carries negative weight, hence subtract on the last bit.
                Sub  = M & last & SIGNED;
                Add  = M & ~(last & SIGNED);
            end
            SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
